// File: rtl/icache_line_refill_if.sv
// Refill engine bus bundle: miss handshake, next-level memory request and
// response, and the cache data array write port.
interface icache_line_refill_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH   = 512,
  parameter int unsigned BEAT_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 512
);
  localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH - 1);

  logic                  MISS_VALID;
  logic [ADDR_WIDTH-1:0] MISS_ADDRESS;
  logic                  MISS_READY;
  logic                  MEM_REQ_VALID;
  logic [ADDR_WIDTH-1:0] MEM_REQ_ADDRESS;
  logic                  MEM_REQ_READY;
  logic                  MEM_RESP_VALID;
  logic [BEAT_WIDTH-1:0] MEM_RESP_DATA;
  logic [IDX_W-1:0]      WRITE_ADDRESS;
  logic [LINE_WIDTH-1:0] DATA_IN;
  logic                  WRITE_ENABLE;
  logic                  REFILL_DONE;

  // Refill engine side
  modport master (
    input  MISS_VALID, MISS_ADDRESS, MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA,
    output MISS_READY, MEM_REQ_VALID, MEM_REQ_ADDRESS, WRITE_ADDRESS, DATA_IN,
           WRITE_ENABLE, REFILL_DONE
  );

  // Miss logic / memory / data array side
  modport slave (
    output MISS_VALID, MISS_ADDRESS, MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA,
    input  MISS_READY, MEM_REQ_VALID, MEM_REQ_ADDRESS, WRITE_ADDRESS, DATA_IN,
           WRITE_ENABLE, REFILL_DONE
  );
endinterface

// File: rtl/icache_line_refill.sv
// Instruction cache line refill engine: accepts a line miss, issues one
// line-aligned read to next-level memory, assembles the returned beats
// (beat 0 least significant) and commits the line with a one-cycle write.
module icache_line_refill #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH   = 512,
  parameter int unsigned BEAT_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 512
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  icache_line_refill_if.master bus
);
  localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH - 1);
  localparam int unsigned BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_COLLECT,
    ST_WRITE
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  miss_ready_q;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [IDX_W-1:0]      waddr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic                  we_q;
  logic                  done_q;

  // Refill FSM with all outputs registered; the line index is taken from the
  // latched aligned address when the last beat lands, so WRITE_ADDRESS only
  // changes at commit time and otherwise holds the previous refill's index.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      miss_ready_q <= 1'b1;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      waddr_q      <= '0;
      line_q       <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.MISS_VALID) begin
            req_addr_q   <= bus.MISS_ADDRESS & ~OFF_MASK;
            req_valid_q  <= 1'b1;
            miss_ready_q <= 1'b0;
            state_q      <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (bus.MEM_REQ_READY) begin
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (bus.MEM_RESP_VALID) begin
            line_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= bus.MEM_RESP_DATA;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              waddr_q <= req_addr_q[OFF_W +: IDX_W];
              we_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          miss_ready_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.MISS_READY      = miss_ready_q;
  assign bus.MEM_REQ_VALID   = req_valid_q;
  assign bus.MEM_REQ_ADDRESS = req_addr_q;
  assign bus.WRITE_ADDRESS   = waddr_q;
  assign bus.DATA_IN         = line_q;
  assign bus.WRITE_ENABLE    = we_q;
  assign bus.REFILL_DONE     = done_q;
endmodule

// File: doc/icache_line_refill.md
Name: icache_line_refill

Overview:
- Refill engine for the instruction cache.
- Accepts a line-miss request and fetches the full line from next-level memory as a burst of narrow beats.
- Assembles the beats into one cache line and commits it to the cache data memory through a single write-port strobe.
- Sits between the cache miss logic and the cache data array; it is the writer side of the array's write port.

Parameters:
- ADDR_WIDTH, 32, byte address width of miss and memory request addresses.
- LINE_WIDTH, 512, cache line width in bits; must equal the data memory width.
- BEAT_WIDTH, 32, width of one memory response beat; LINE_WIDTH must be an integer multiple.
- MEMORY_DEPTH, 512, number of lines in the data memory; index width IDX_W = $clog2(MEMORY_DEPTH-1).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- MISS_VALID  in  1  miss request valid.
- MISS_ADDRESS  in  ADDR_WIDTH  byte address of the missing fetch.
- MISS_READY  out  1  engine idle, miss can be accepted.
- MEM_REQ_VALID  out  1  line read request to next level.
- MEM_REQ_ADDRESS  out  ADDR_WIDTH  line-aligned request address.
- MEM_REQ_READY  in  1  next level accepts the request.
- MEM_RESP_VALID  in  1  one response beat valid this cycle; no backpressure.
- MEM_RESP_DATA  in  BEAT_WIDTH  response beat data.
- WRITE_ADDRESS  out  IDX_W  data memory line index.
- DATA_IN  out  LINE_WIDTH  assembled line to data memory.
- WRITE_ENABLE  out  1  data memory write strobe.
- REFILL_DONE  out  1  one-cycle pulse; line committed.

Behaviour:
- Definitions:
  - BEATS = LINE_WIDTH/BEAT_WIDTH (default 16).
  - OFF_W = $clog2(LINE_WIDTH/8) (default 6).
  - Line index = MISS_ADDRESS[OFF_W +: IDX_W].
- Reset (RST_N=0 at a rising edge), from any state:
  - State goes to IDLE; beat counter goes to 0.
  - MISS_READY=1; MEM_REQ_VALID=0, MEM_REQ_ADDRESS=0, WRITE_ADDRESS=0, DATA_IN=0, WRITE_ENABLE=0, REFILL_DONE=0.
  - A refill in progress is abandoned with no write; beats arriving after reset are ignored.
- IDLE:
  - MISS_READY=1.
  - On MISS_VALID=1, latch MISS_ADDRESS with bits [OFF_W-1:0] forced to 0, latch the line index, go to REQUEST.
- REQUEST:
  - MISS_READY=0, MEM_REQ_VALID=1, MEM_REQ_ADDRESS = latched aligned address, held stable until accepted.
  - On MEM_REQ_READY=1, clear the beat counter and go to COLLECT.
- COLLECT:
  - Each cycle with MEM_RESP_VALID=1 writes MEM_RESP_DATA into DATA_IN[cnt*BEAT_WIDTH +: BEAT_WIDTH] (beat 0 = least significant) and increments cnt.
  - Gaps (VALID=0) are allowed and leave state unchanged.
  - The beat with cnt==BEATS-1 moves the engine to WRITE.
- WRITE (exactly one cycle):
  - WRITE_ENABLE=1, REFILL_DONE=1, WRITE_ADDRESS = latched index, DATA_IN = full line.
  - Next state is IDLE.
- Outputs are registered.
  - DATA_IN and WRITE_ADDRESS hold their values after WRITE until the next refill.
  - WRITE_ENABLE and REFILL_DONE are 0 outside WRITE.
- MEM_RESP_VALID outside COLLECT (IDLE, REQUEST, WRITE) is ignored; no data capture and no counter change.
- MISS_VALID outside IDLE is ignored; the requester must hold it until MISS_READY.
- Latency, with the miss accepted at edge T and MEM_REQ_READY=1 immediately:
  - T+1: MEM_REQ_VALID=1.
  - T+2 to T+17: beats captured if back-to-back.
  - T+18: WRITE cycle.
  - T+19: MISS_READY=1.
  - Minimum miss-to-miss spacing is BEATS+3 cycles.
- Counter width is $clog2(BEATS); it wraps to 0 on entry to COLLECT, never during a burst.

Test Plan:
- Basic refill:
  - Stimulus: reset, MISS_ADDRESS=0x0000_1234, MEM_REQ_READY=1, 16 back-to-back beats 0x0..0xF.
  - Response: MEM_REQ_ADDRESS=0x0000_1200, WRITE_ADDRESS=0x048, DATA_IN[31:0]=0 and DATA_IN[511:480]=0xF, single WRITE_ENABLE/REFILL_DONE pulse at T+18.
- Request backpressure:
  - Stimulus: MEM_REQ_READY low for 5 cycles.
  - Response: MEM_REQ_VALID and MEM_REQ_ADDRESS stable for those 5 cycles; no beat captured before acceptance; the WRITE cycle is delayed by 5.
- Gapped beats:
  - Stimulus: MEM_RESP_VALID toggling 1/0, plus stray beats in REQUEST and after WRITE.
  - Response: stray beats ignored; the line is assembled correctly; exactly one write.
- Reset mid-burst:
  - Stimulus: RST_N=0 after beat 7 of 16, then a new miss at 0xFFFF_FFC0 with a full burst.
  - Response: no WRITE_ENABLE from the aborted refill; the second refill writes index 0x1FF correctly.
- Back-to-back misses:
  - Stimulus: MISS_VALID held high with a new address during a refill.
  - Response: MISS_READY=0 until T+19; the second miss is accepted at T+19 and its WRITE_ADDRESS reflects the second address.
- Width variant:
  - Stimulus: BEAT_WIDTH=64.
  - Response: exactly 8 beats complete the line.
